sha2_block_engine: RTL and testbench

Parametrised successor to sha256_core. Accepts whole 512-bit padded message blocks, expands the message schedule W[t] internally and holds K[t] in an internal ROM. Chains multi-block messages, supports SHA-256 and SHA-224, and computes UNROLL rounds per clock. Sits between the padding/block-assembly front end and the digest consumer (host register bank or HMAC wrapper).

---
 rtl/sha2_pkg.sv | 61 ++++++
 rtl/sha2_round.sv | 28 ++
 rtl/sha2_block_engine.sv | 163 ++++++++++++++++
 tb/tb_sha2_block_engine.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha2_pkg.sv
// ----------------------------------------------------------------------------
// sha2_pkg: SHA-256/224 constants, state encoding and round helper functions
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package sha2_pkg;

  localparam int STATE_W = 2;
  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ROUND = 2'd1;
  localparam logic [STATE_W-1:0] FINAL = 2'd2;

  // Word 0 (H0 / a) sits in bits [255:224]
  localparam logic [255:0] IV_256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV_224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

  function automatic logic [31:0] Sigma0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] Sigma1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sha2_round.sv
// ----------------------------------------------------------------------------
// sha2_round: one combinational SHA-2 compression round on packed {a..h}
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha2_round
  import sha2_pkg::*;
(
  input  logic [255:0] state_i,
  input  logic [31:0]  w_i,
  input  logic [31:0]  k_i,
  output logic [255:0] state_o
);

  logic [31:0] w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h;
  logic [31:0] w_t1, w_t2;

  assign {w_a, w_b, w_c, w_d, w_e, w_f, w_g, w_h} = state_i;

  assign w_t1 = w_h + Sigma1(w_e) + ch(w_e, w_f, w_g) + k_i + w_i;
  assign w_t2 = Sigma0(w_a) + maj(w_a, w_b, w_c);

  assign state_o = {w_t1 + w_t2, w_a, w_b, w_c, w_d + w_t1, w_e, w_f, w_g};

endmodule

`default_nettype wire

// File: rtl/sha2_block_engine.sv
// ----------------------------------------------------------------------------
// sha2_block_engine: chained SHA-256/224 block compression, UNROLL rounds/clock
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module sha2_block_engine
  import sha2_pkg::*;
#(
  parameter int UNROLL      = 1,
  parameter bit SUPPORT_224 = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid_i,
  output logic         blk_ready_o,
  input  logic [511:0] blk_data_i,
  input  logic         blk_first_i,
  input  logic         blk_last_i,
  input  logic         mode_224_i,
  output logic         busy_o,
  output logic         digest_valid_o,
  output logic [255:0] digest_o
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
    $error("sha2_block_engine: UNROLL must be 1, 2 or 4");
  end

  logic [STATE_W-1:0] state_q, state_d;
  logic [5:0]         t_q, t_d;
  logic [31:0]        win_q [16];
  logic [31:0]        win_d [16];
  logic [255:0]       work_q, work_d;
  logic [255:0]       h_q, h_d;
  logic [255:0]       digest_q, digest_d;
  logic               mode_q, mode_d;
  logic               last_q, last_d;
  logic               dv_q, dv_d;

  logic [31:0]        w_ext [16+UNROLL];
  logic [255:0]       w_round_out;
  logic [255:0]       w_h_sum;
  logic               w_mode_sel;
  logic [255:0]       w_iv;

  assign w_mode_sel = SUPPORT_224 ? mode_224_i : 1'b0;
  assign w_iv       = w_mode_sel ? IV_224 : IV_256;

  // Window always holds W[t..t+15]; the UNROLL words past its end are expanded here
  always_comb begin
    for (int i = 0; i < 16; i++) w_ext[i] = win_q[i];
    for (int u = 0; u < UNROLL; u++)
      w_ext[16+u] = sigma1(w_ext[14+u]) + w_ext[9+u] + sigma0(w_ext[1+u]) + w_ext[u];
  end

  for (genvar u = 0; u < UNROLL; u++) begin : g_round
    logic [255:0] w_in;
    logic [255:0] w_out;
    logic [5:0]   w_t_idx;

    if (u == 0) begin : g_head
      assign w_in = work_q;
    end else begin : g_link
      assign w_in = g_round[u-1].w_out;
    end

    assign w_t_idx = t_q + 6'(u);

    sha2_round u_round (
      .state_i (w_in),
      .w_i     (w_ext[u]),
      .k_i     (K_ROM[w_t_idx]),
      .state_o (w_out)
    );
  end

  assign w_round_out = g_round[UNROLL-1].w_out;

  always_comb begin
    for (int i = 0; i < 8; i++) w_h_sum[32*i +: 32] = h_q[32*i +: 32] + work_q[32*i +: 32];
  end

  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    win_d    = win_q;
    work_d   = work_q;
    h_d      = h_q;
    digest_d = digest_q;
    mode_d   = mode_q;
    last_d   = last_q;
    dv_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (blk_valid_i) begin
          for (int i = 0; i < 16; i++) win_d[i] = blk_data_i[511-32*i -: 32];
          if (blk_first_i) begin
            mode_d = w_mode_sel;
            h_d    = w_iv;
            work_d = w_iv;
          end else begin
            work_d = h_q;
          end
          last_d  = blk_last_i;
          t_d     = 6'd0;
          state_d = ROUND;
        end
      end
      ROUND: begin
        work_d = w_round_out;
        for (int i = 0; i < 16; i++) win_d[i] = w_ext[i+UNROLL];
        if (t_q == 6'(64 - UNROLL)) begin
          t_d     = 6'd0;
          state_d = FINAL;
        end else begin
          t_d = t_q + 6'(UNROLL);
        end
      end
      FINAL: begin
        h_d = w_h_sum;
        if (last_q) begin
          digest_d = mode_q ? {w_h_sum[255:32], 32'h0} : w_h_sum;
          dv_d     = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      t_q      <= 6'd0;
      for (int i = 0; i < 16; i++) win_q[i] <= 32'h0;
      work_q   <= 256'h0;
      h_q      <= IV_256;
      digest_q <= 256'h0;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      dv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      t_q      <= t_d;
      win_q    <= win_d;
      work_q   <= work_d;
      h_q      <= h_d;
      digest_q <= digest_d;
      mode_q   <= mode_d;
      last_q   <= last_d;
      dv_q     <= dv_d;
    end
  end

  assign blk_ready_o    = (state_q == IDLE);
  assign busy_o         = (state_q != IDLE);
  assign digest_valid_o = dv_q;
  assign digest_o       = digest_q;

endmodule

`default_nettype wire

// File: tb/tb_sha2_block_engine.sv
// ----------------------------------------------------------------------------
// tb_sha2_block_engine: three engines (UNROLL 1/2/4) against a block-level SHA-2 model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_sha2_block_engine;

  localparam logic [255:0] IV256 =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] IV224 =
    256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;
  localparam logic [511:0] ABC_BLK   = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
  localparam logic [511:0] TWO_B1 = {
    128'h61626364_62636465_63646566_64656667, 128'h65666768_66676869_6768696a_68696a6b,
    128'h696a6b6c_6a6b6c6d_6b6c6d6e_6c6d6e6f, 128'h6d6e6f70_6e6f7071_80000000_00000000};
  localparam logic [511:0] TWO_B2 = {448'h0, 64'h1c0};
  localparam logic [255:0] ABC256 =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY256 =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO256 =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
  localparam logic [255:0] ABC224 =
    {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};

  logic         clk;
  logic         rst_n;
  logic [2:0]   valid;
  logic [511:0] data;
  logic         first, last, mode;
  logic [2:0]   ready, busy, dv;
  logic [255:0] dig [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sha2_block_engine #(.UNROLL(1 << g), .SUPPORT_224(1'b1)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .blk_valid_i    (valid[g]),
      .blk_ready_o    (ready[g]),
      .blk_data_i     (data),
      .blk_first_i    (first),
      .blk_last_i     (last),
      .mode_224_i     (mode),
      .busy_o         (busy[g]),
      .digest_valid_o (dv[g]),
      .digest_o       (dig[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0]  k_tb [64];
  int           lat_exp [3];
  int           n_tests, n_fail;
  int           cyc;
  bit           chk_en;

  // Block-level model: remaining busy cycles per engine, chaining value, published digest
  int           rem [3];
  logic [255:0] mh [3], pend [3], mdig [3];
  logic         mmode [3], mlast [3], mdv [3];
  int           dvcnt [3];

  // Literal checks are handed to the compare process, which owns the counters
  string        lit_name;
  logic [259:0] lit_act, lit_exp;
  bit           lit_tog, lit_seen;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0]  w [64];
    logic [31:0]  v [8];
    logic [31:0]  t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_tb[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        if (!rst_n) begin
          rem[i] = 0; mh[i] = IV256; mmode[i] = 1'b0; mlast[i] = 1'b0;
          mdig[i] = 256'h0; mdv[i] = 1'b0;
        end else begin
          mdv[i] = 1'b0;
          if (rem[i] == 0) begin
            if (valid[i]) begin
              if (first) begin
                mmode[i] = mode;
                mh[i]    = mode ? IV224 : IV256;
              end
              pend[i]  = compress(mh[i], data);
              mlast[i] = last;
              rem[i]   = 64 / (1 << i) + 1;
            end
          end else begin
            rem[i]--;
            if (rem[i] == 0) begin
              mh[i] = pend[i];
              if (mlast[i]) begin
                mdig[i] = mmode[i] ? {pend[i][255:32], 32'h0} : pend[i];
                mdv[i]  = 1'b1;
              end
            end
          end
        end
      end
      chk_en = 1'b1;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < 3; i++) begin
          n_tests++;
          if ({ready[i], busy[i], dv[i], dig[i]} !== {rem[i] == 0, rem[i] != 0, mdv[i], mdig[i]}) begin
            n_fail++;
            $display("FAIL cycle_check inst=%0d cyc=%0d actual=%h required=%h", i, cyc,
                     {ready[i], busy[i], dv[i], dig[i]}, {rem[i] == 0, rem[i] != 0, mdv[i], mdig[i]});
          end
          if (dv[i]) dvcnt[i]++;
        end
      end
      if (lit_tog != lit_seen) begin
        lit_seen = lit_tog;
        n_tests++;
        if (lit_act !== lit_exp) begin
          n_fail++;
          $display("FAIL %s actual=%h required=%h", lit_name, lit_act, lit_exp);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic post(input string nm, input logic [259:0] a, input logic [259:0] e);
    lit_name = nm;
    lit_act  = a;
    lit_exp  = e;
    lit_tog  = ~lit_tog;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge; returns one negedge after the engine is idle again
  task automatic send(input int i, input logic [511:0] b, input logic f, input logic l,
                      input logic m, output int lat);
    int n;
    int t0;
    data = b; first = f; last = l; mode = m;
    valid[i] = 1'b1;
    n = 0;
    while (!ready[i] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) post("ready_timeout", 260'(0), 260'(1));
    t0 = cyc + 1;
    @(negedge clk);
    valid[i] = 1'b0;
    n = 0;
    while (busy[i] && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) post("busy_timeout", 260'(0), 260'(1));
    lat = cyc - t0;
    @(negedge clk);
  endtask

  int           lat, p0, nb;
  logic [511:0] rb;

  initial begin
    k_tb = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    lat_exp = '{65, 33, 17};
    rst_n = 1'b0; valid = 3'b000; data = '0; first = 1'b0; last = 1'b0; mode = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 3; i++)
      post("reset_state", {1'b0, ready[i], busy[i], dv[i], dig[i]}, {1'b0, 1'b1, 1'b0, 1'b0, 256'h0});

    for (int i = 0; i < 3; i++) begin
      send(i, ABC_BLK, 1'b1, 1'b1, 1'b0, lat);
      post("abc_latency", 260'(lat), 260'(lat_exp[i]));
      post("abc256", 260'(dig[i]), 260'(ABC256));
      post("model_abc256", 260'(mdig[i]), 260'(ABC256));
      send(i, EMPTY_BLK, 1'b1, 1'b1, 1'b0, lat);
      post("empty256", 260'(dig[i]), 260'(EMPTY256));
      p0 = dvcnt[i];
      send(i, TWO_B1, 1'b1, 1'b0, 1'b0, lat);
      post("two_blk_no_early_pulse", 260'(dvcnt[i] - p0), 260'(0));
      post("two_blk_digest_held", 260'(dig[i]), 260'(EMPTY256));
      send(i, TWO_B2, 1'b0, 1'b1, 1'b1, lat);
      post("two_blk_one_pulse", 260'(dvcnt[i] - p0), 260'(1));
      post("two_blk", 260'(dig[i]), 260'(TWO256));
      send(i, ABC_BLK, 1'b1, 1'b1, 1'b1, lat);
      post("abc224", 260'(dig[i]), 260'(ABC224));
      post("model_abc224", 260'(mdig[i]), 260'(ABC224));
    end

    // Valid held through ROUND, then reset lands mid-block
    data = ABC_BLK; first = 1'b1; last = 1'b1; mode = 1'b0;
    valid = 3'b111;
    repeat (31) @(negedge clk);
    rst_n = 1'b0;
    valid = 3'b000;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      post("post_reset_state", {1'b0, ready[i], busy[i], dv[i], dig[i]}, {1'b0, 1'b1, 1'b0, 1'b0, 256'h0});

    // Non-first block right after reset chains from the SHA-256 IV; mode input ignored
    for (int i = 0; i < 3; i++) begin
      send(i, ABC_BLK, 1'b0, 1'b1, 1'b1, lat);
      post("chain_from_reset_iv", 260'(dig[i]), 260'(ABC256));
    end

    for (int i = 0; i < 3; i++) begin
      for (int m = 0; m < 3; m++) begin
        nb = $urandom_range(1, 3);
        for (int b = 0; b < nb; b++) begin
          for (int w = 0; w < 16; w++) rb[511-32*w -: 32] = $urandom();
          send(i, rb, (b == 0) ? ($urandom_range(0, 3) != 0) : 1'b0, (b == nb - 1),
               1'($urandom_range(0, 1)), lat);
          post("rand_latency", 260'(lat), 260'(lat_exp[i]));
        end
      end
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
